control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Fetch/decode/execute FSM directly downstream of the instruction register (IR).
//  - Consumes the IR's 16-bit output and generates all datapath strobes: memory fetch request,
//    IR load enable, PC increment/load, register-file addresses and write enable, ALU op, immediate.
//  - Moore-style: strobes are decoded from the state register.
//  - Instruction fields are latched in DECODE and held through EXECUTE/WRITEBACK.
// PARAMETERS
//  WIDTH      16  instruction/data width; instr fields: op=[15:12] rd=[11:8] rs=[7:4] rt=[3:0]
//  TIMEOUT    255 max FETCH cycles without mem_ack before fault (1..2^TMO_W-1)
//  TMO_W      8   width of fetch timeout counter
// PORTS
//  clk        in  1      system clock, all state changes on rising edge
//  reset      in  1      asynchronous, active-low; forces RST state and all outputs 0
//  ir_out     in  WIDTH  current instruction from IR
//  mem_ack    in  1      memory has valid instruction on bus; sampled in FETCH only
//  zero_flag  in  1      ALU zero flag, sampled in EXECUTE
//  mem_req    out 1      instruction read request (PC drives address)
//  ir_en      out 1      IR load enable, one-cycle pulse
//  pc_inc     out 1      PC += 1, one-cycle pulse
//  pc_load    out 1      PC <= pc_target, one-cycle pulse
//  pc_target  out 12     jump/branch target = latched ir[11:0]
//  rf_ra/rf_rb out 4     register-file read addresses (latched rs/rt)
//  rf_wa      out 4      register-file write address (latched rd)
//  rf_we      out 1      register-file write enable, one-cycle pulse
//  alu_op     out 3      0 PASS_IMM,1 ADD,2 SUB,3 AND,4 OR,5 XOR
//  imm_out    out WIDTH  sign-extended latched ir[7:0]
//  halted     out 1      1 in HALT state
//  fault      out 1      sticky: fetch timeout or illegal opcode
// BEHAVIOUR
//  States: RST -> FETCH -> LOAD_IR -> DECODE -> EXECUTE -> [WRITEBACK] -> FETCH; HALT terminal.
//  RST: all outputs 0; leaves to FETCH on first clk after reset deasserts.
//  FETCH: mem_req=1; mem_ack=1 -> LOAD_IR; timeout counter cleared on FETCH entry, +1 per cycle;
//    count reaches TIMEOUT without ack -> fault=1, HALT. Ack on the TIMEOUT-th cycle wins (no fault).
//  LOAD_IR: ir_en=1 and pc_inc=1 same cycle -> DECODE. mem_ack outside FETCH ignored.
//  DECODE: latch ir_out fields/opcode into internal regs -> EXECUTE (ir_out valid this cycle).
//  EXECUTE by opcode: 0 NOP->FETCH; 1-5 ALU (alu_op=op) ->WRITEBACK; 6 LDI (alu_op=0) ->WRITEBACK;
//    7 JMP pc_load=1 ->FETCH; 8 BZ pc_load=zero_flag ->FETCH; F HALT ->HALT;
//    9-E illegal: fault=1, treated as NOP ->FETCH.
//  WRITEBACK: rf_we=1 -> FETCH.
//  Latency with immediate ack: ALU/LDI 5 cycles, NOP/JMP/BZ 4 cycles, FETCH to FETCH.
//  rf_ra/rb/wa, alu_op, imm_out, pc_target hold latched values until next DECODE; 0 after reset.
//  HALT: halted=1, all strobes 0, exit only via reset. fault cleared only by reset.
//  Reset mid-operation (any state): immediate abort, outputs 0, no partial writes.
// CONFIGURATION
//  SINGLE_STEP_EN defined: adds input port step (1 bit). FETCH entered only after a step
//    rising edge (registered edge detect); between instructions FSM waits in STEP_WAIT, all strobes 0,
//    timeout counter idle. Step edge during an instruction is ignored (not queued).
//  SINGLE_STEP_EN undefined: no step port, no STEP_WAIT; FETCH follows immediately.
// TESTING
//  reset low, then high -> cycle 1 RST outputs 0; cycle 2 mem_req=1.
//  ack in 1st FETCH cycle, ir_out=16'h1123 (ADD r1,r2,r3) -> ir_en+pc_inc in LOAD_IR;
//    EXECUTE alu_op=1, rf_ra=2, rf_rb=3; rf_we=1 with rf_wa=1 in 5th cycle.
//  ir_out=16'h8040 BZ with zero_flag=1 -> pc_load=1, pc_target=12'h040;
//    zero_flag=0 -> pc_load=0; both next state FETCH.
//  ir_out=16'h6AFF LDI -> imm_out=16'hFFFF, rf_wa=10, alu_op=0.
//  mem_ack held 0 for TIMEOUT cycles -> fault=1, halted=1; ack on cycle TIMEOUT -> no fault.
//  ir_out=16'hF000 -> halted=1 forever; reset low mid-WRITEBACK -> rf_we drops same cycle, state RST.

Source files
------------

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Fetch/decode/execute sequencer that sits directly after the instruction
// register (IR). It generates all datapath strobes for a simple 16-bit machine:
// the instruction fetch request, IR load, PC increment/load, register-file
// addresses and write enable, ALU operation and a sign-extended immediate.
//
// Moore style: strobes are decoded from the state register. The one input that
// reaches an output combinationally is zero_flag, which gates pc_load for a
// BZ instruction in EXECUTE.
//
// Instruction format (ir_out): op=[15:12] rd=[11:8] rs=[7:4] rt=[3:0]
//   0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 LDI, 7 JMP, 8 BZ,
//   9..E illegal (fault, then behaves as NOP), F HALT.
//
// State flow: RST -> FETCH -> LOAD_IR -> DECODE -> EXECUTE -> [WRITEBACK]
//             -> FETCH ; HALT is terminal (left only through reset).
//
// Parameters
//   WIDTH    instruction/data width (field positions assume WIDTH >= 16)
//   TIMEOUT  FETCH cycles without mem_ack before a fault (1 .. 2**TMO_W-1)
//   TMO_W    width of the fetch timeout counter
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low; forces RST and zero outputs
//   ir_out     in   current instruction from the IR
//   mem_ack    in   instruction valid on bus (looked at in FETCH only)
//   zero_flag  in   ALU zero flag (looked at in EXECUTE for BZ)
//   step       in   single-step request (only with SINGLE_STEP_EN)
//   mem_req    out  instruction read request
//   ir_en      out  IR load enable pulse
//   pc_inc     out  PC increment pulse
//   pc_load    out  PC load pulse (JMP, or BZ with zero_flag set)
//   pc_target  out  latched ir[11:0]
//   rf_ra      out  latched rs
//   rf_rb      out  latched rt
//   rf_wa      out  latched rd
//   rf_we      out  register-file write enable pulse (WRITEBACK)
//   alu_op     out  latched ALU op (0 PASS_IMM, 1 ADD .. 5 XOR)
//   imm_out    out  latched sign-extended ir[7:0]
//   halted     out  1 while in HALT
//   fault      out  sticky fetch-timeout / illegal-opcode indication
//
// Build option
//   SINGLE_STEP_EN  when defined, adds the step input and a STEP_WAIT state:
//                   each instruction starts only after a rising edge on step.
//                   Edges seen while an instruction is running are dropped.
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255,
  parameter int TMO_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ir_out,
  input  logic             mem_ack,
  input  logic             zero_flag,
`ifdef SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             mem_req,
  output logic             ir_en,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [11:0]      pc_target,
  output logic [3:0]       rf_ra,
  output logic [3:0]       rf_rb,
  output logic [3:0]       rf_wa,
  output logic             rf_we,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] imm_out,
  output logic             halted,
  output logic             fault
);

  typedef enum logic [2:0] {
    S_RST       = 3'd0,
    S_FETCH     = 3'd1,
    S_LOAD_IR   = 3'd2,
    S_DECODE    = 3'd3,
    S_EXECUTE   = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_STEP_WAIT = 3'd7
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_BZ   = 4'h8;
  localparam logic [3:0] OP_ILLO = 4'h9;
  localparam logic [3:0] OP_ILHI = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // The counter value seen during the TIMEOUT-th consecutive FETCH cycle.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  state_t           w_idle;          // where an instruction goes when it is done

  logic [TMO_W-1:0] r_tmo;
  logic             r_fault;

  // Fields captured in DECODE and held until the next DECODE.
  logic [3:0]       r_op;
  logic [3:0]       r_rd;
  logic [3:0]       r_rs;
  logic [3:0]       r_rt;
  logic [11:0]      r_target;
  logic [WIDTH-1:0] r_imm;
  logic [2:0]       r_alu_op;

  logic [3:0]       w_ir_op;
  logic [2:0]       w_dec_alu_op;
  logic             w_tmo_hit;
  logic             w_fetch_timeout;
  logic             w_op_writes;
  logic             w_exec_illegal;

  // ---------------------------------------------------------------------------
  // Single-step front end
  // ---------------------------------------------------------------------------
`ifdef SINGLE_STEP_EN
  logic r_step_q;
  logic r_step_qq;
  logic w_step_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_step_q  <= 1'b0;
      r_step_qq <= 1'b0;
    end else begin
      r_step_q  <= step;
      r_step_qq <= r_step_q;
    end
  end

  // One-cycle pulse; it is only consumed in STEP_WAIT, so edges arriving
  // mid-instruction are simply lost rather than queued.
  assign w_step_rise = r_step_q & ~r_step_qq;
  assign w_idle      = S_STEP_WAIT;
`else
  assign w_idle      = S_FETCH;
`endif

  // ---------------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------------
  assign w_ir_op      = ir_out[15:12];
  assign w_dec_alu_op = ((w_ir_op >= OP_ADD) && (w_ir_op <= OP_XOR)) ? w_ir_op[2:0] : 3'd0;

  assign w_tmo_hit       = (r_tmo == TMO_LAST);
  // An ack in the last allowed cycle still wins over the timeout.
  assign w_fetch_timeout = (r_state == S_FETCH) && !mem_ack && w_tmo_hit;

  // ALU ops and LDI both finish with a register write.
  assign w_op_writes    = (r_op >= OP_ADD) && (r_op <= OP_LDI);
  assign w_exec_illegal = (r_state == S_EXECUTE) && (r_op >= OP_ILLO) && (r_op <= OP_ILHI);

  // ---------------------------------------------------------------------------
  // Process 1: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked blocks use non-blocking (<=) so every register samples the
  // pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_RST;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch timeout counter and sticky fault
  // ---------------------------------------------------------------------------
  // Held at zero outside FETCH, so it is always zero on FETCH entry and idle
  // while waiting for a step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo <= '0;
    end else if (r_state == S_FETCH) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end else begin
      r_tmo <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fault <= 1'b0;
    end else if (w_fetch_timeout || w_exec_illegal) begin
      r_fault <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction field latch (the IR is valid during DECODE)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op     <= OP_NOP;
      r_rd     <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_target <= '0;
      r_imm    <= '0;
      r_alu_op <= '0;
    end else if (r_state == S_DECODE) begin
      r_op     <= w_ir_op;
      r_rd     <= ir_out[11:8];
      r_rs     <= ir_out[7:4];
      r_rt     <= ir_out[3:0];
      r_target <= ir_out[11:0];
      r_imm    <= {{(WIDTH-8){ir_out[7]}}, ir_out[7:0]};
      r_alu_op <= w_dec_alu_op;
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: w_next gets a default before the case so every path assigns it;
  // without that, always_comb would infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST:       w_next = w_idle;
      S_FETCH: begin
        if (mem_ack) begin
          w_next = S_LOAD_IR;
        end else if (w_tmo_hit) begin
          w_next = S_HALT;
        end
      end
      S_LOAD_IR:   w_next = S_DECODE;
      S_DECODE:    w_next = S_EXECUTE;
      S_EXECUTE: begin
        if (r_op == OP_HALT) begin
          w_next = S_HALT;
        end else if (w_op_writes) begin
          w_next = S_WRITEBACK;
        end else begin
          // NOP, JMP, BZ and illegal opcodes all go straight back.
          w_next = w_idle;
        end
      end
      S_WRITEBACK: w_next = w_idle;
      S_HALT:      w_next = S_HALT;
`ifdef SINGLE_STEP_EN
      S_STEP_WAIT: begin
        if (w_step_rise) begin
          w_next = S_FETCH;
        end
      end
`endif
      default:     w_next = S_RST;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Process 3: output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req = 1'b0;
    ir_en   = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    rf_we   = 1'b0;
    halted  = 1'b0;
    case (r_state)
      S_FETCH:     mem_req = 1'b1;
      S_LOAD_IR: begin
        ir_en  = 1'b1;
        pc_inc = 1'b1;
      end
      S_EXECUTE: begin
        if (r_op == OP_JMP) begin
          pc_load = 1'b1;
        end else if (r_op == OP_BZ) begin
          pc_load = zero_flag;
        end
      end
      S_WRITEBACK: rf_we  = 1'b1;
      S_HALT:      halted = 1'b1;
      default: ;
    endcase
  end

  // Fault shows up already in the EXECUTE cycle of an illegal opcode and then
  // stays set through the sticky register.
  assign fault     = r_fault | w_exec_illegal;

  assign pc_target = r_target;
  assign rf_ra     = r_rs;
  assign rf_rb     = r_rt;
  assign rf_wa     = r_rd;
  assign alu_op    = r_alu_op;
  assign imm_out   = r_imm;

endmodule
